// File: rtl/bch_enc_arbiter_if.sv
// Handshake bundle between the message sources, the shared-encoder arbiter and downstream TX.
// master = producers/consumer side, slave = arbiter.
interface bch_enc_arbiter_if #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ID_W    = 2
) ();
    logic [NUM_REQ-1:0]   req_valid;
    logic [NUM_REQ-1:0]   req_ready;
    logic [7*NUM_REQ-1:0] req_msg;
    logic                 out_valid;
    logic                 out_ready;
    logic [14:0]          out_codeword;
    logic [ID_W-1:0]      out_id;

    modport master (
        output req_valid,
        output req_msg,
        input  req_ready,
        input  out_valid,
        input  out_codeword,
        input  out_id,
        output out_ready
    );

    modport slave (
        input  req_valid,
        input  req_msg,
        output req_ready,
        output out_valid,
        output out_codeword,
        output out_id,
        input  out_ready
    );
endinterface

// File: rtl/bch_enc_arbiter.sv
// Round-robin scheduler sharing one external BCH(15,7) encoder among NUM_REQ sources.
// One message in flight at a time; the codeword is captured after ENC_LAT cycles and held.
module bch_enc_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ID_W    = 2,
    parameter int unsigned ENC_LAT = 1
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    bch_enc_arbiter_if.slave      io_bus,
    output logic [6:0]            o_enc_msg,
    input  logic [14:0]           i_enc_codeword,
    output logic                  o_busy,
    output logic                  o_err_mismatch
);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StWait = 2'd1;
    localparam logic [1:0] StOut  = 2'd2;

    localparam int unsigned      CNT_W   = $clog2(ENC_LAT + 1);
    localparam logic [CNT_W-1:0] CntLast = CNT_W'(ENC_LAT);
    localparam logic [ID_W:0]    NumReqW = (ID_W + 1)'(NUM_REQ);
    localparam logic [ID_W-1:0]  PtrRst  = ID_W'(NUM_REQ - 1);

    logic [1:0]         r_state;
    logic [ID_W-1:0]    r_ptr;
    logic [ID_W-1:0]    r_id;
    logic [CNT_W-1:0]   r_cnt;
    logic [6:0]         r_enc_msg;
    logic               r_out_valid;
    logic [14:0]        r_out_codeword;
    logic [ID_W-1:0]    r_out_id;
    logic               r_err;

    logic               w_found;
    logic [ID_W-1:0]    w_winner;
    logic [ID_W:0]      w_sum;
    logic [ID_W-1:0]    w_idx;
    logic [6:0]         w_sel_msg;
    logic [NUM_REQ-1:0] w_req_ready;
    logic               w_grant;

    // Search from pointer+1 upward with wraparound; the first asserted valid wins.
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        w_sum    = '0;
        w_idx    = '0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            w_sum = {1'b0, r_ptr} + (ID_W + 1)'(k);
            w_idx = (w_sum >= NumReqW) ? ID_W'(w_sum - NumReqW) : ID_W'(w_sum);
            if (!w_found && io_bus.req_valid[w_idx]) begin
                w_found  = 1'b1;
                w_winner = w_idx;
            end
        end
    end

    assign w_grant = (r_state == StIdle) && w_found;

    always_comb begin
        w_sel_msg   = '0;
        w_req_ready = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (w_winner == ID_W'(i)) begin
                w_sel_msg = io_bus.req_msg[7*i +: 7];
            end
            w_req_ready[i] = w_grant && (w_winner == ID_W'(i));
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state        <= StIdle;
            r_ptr          <= PtrRst;
            r_id           <= '0;
            r_cnt          <= '0;
            r_enc_msg      <= '0;
            r_out_valid    <= 1'b0;
            r_out_codeword <= '0;
            r_out_id       <= '0;
            r_err          <= 1'b0;
        end else begin
            case (r_state)
                StIdle: begin
                    if (w_grant) begin
                        r_enc_msg <= w_sel_msg;
                        r_id      <= w_winner;
                        r_ptr     <= w_winner;
                        r_cnt     <= '0;
                        r_state   <= StWait;
                    end
                end
                StWait: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == CntLast) begin
                        r_out_codeword <= i_enc_codeword;
                        r_out_id       <= r_id;
                        r_out_valid    <= 1'b1;
                        r_state        <= StOut;
                        // Systematic code: the upper bits must echo the issued message.
                        if (i_enc_codeword[14:8] != r_enc_msg) begin
                            r_err <= 1'b1;
                        end
                    end
                end
                StOut: begin
                    if (io_bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= StIdle;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign io_bus.req_ready    = w_req_ready;
    assign io_bus.out_valid    = r_out_valid;
    assign io_bus.out_codeword = r_out_codeword;
    assign io_bus.out_id       = r_out_id;
    assign o_enc_msg           = r_enc_msg;
    assign o_busy              = (r_state != StIdle);
    assign o_err_mismatch      = r_err;

endmodule
